aes_key_schedule: RTL and testbench

Sequential AES-128 key expansion stage that sits directly upstream of the AES decryption core's round datapath. Software loads the 128-bit cipher key. This block then generates all 11 round keys, one per clock. It stores them in an internal key RAM, which the core reads by round index, with round 10 read first during decryption. This replaces per-round key recomputation inside the core and frees the core's FSM from key timing.

---
 rtl/aes_key_schedule.sv | 151 +++++++++++++++
 tb/tb_aes_key_schedule.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - AES-128 key expansion into an 11-entry round-key store
// Forward S-box byte lookup plus the sequential key schedule that uses it.

module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign s_o = SBOX[a_i];
endmodule

module aes_key_schedule #(
    parameter int NROUNDS = 10
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         KEY_START,
    input  logic [127:0] CIPHER_KEY,
    output logic         KEY_BUSY,
    output logic         KEY_READY,
    input  logic [3:0]   RK_INDEX,
    output logic [127:0] RK_OUT
);
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    localparam logic [3:0] LAST = 4'(NROUNDS);

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] rk_q [NROUNDS+1];
    logic [127:0] rk_out_q;

    logic         wr_en;
    logic [3:0]   wr_idx;
    logic [127:0] wr_data;

    logic [3:0]   prev_idx;
    logic [127:0] prev_rk;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  rot_w, sub_w, t_w;
    logic [31:0]  n0, n1, n2, n3;
    logic [7:0]   rcon;

    // cnt is 0 only outside EXPAND, so the clamp just keeps the index in range.
    assign prev_idx = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    assign prev_rk  = rk_q[prev_idx];
    assign {p0, p1, p2, p3} = prev_rk;
    assign rot_w    = {p3[23:0], p3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sbox u_sbox (
            .a_i (rot_w[8*g +: 8]),
            .s_o (sub_w[8*g +: 8])
        );
    end

    always_comb begin
        rcon = 8'h00;
        case (cnt_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign t_w = sub_w ^ {rcon, 24'h0};
    assign n0  = p0 ^ t_w;
    assign n1  = p1 ^ n0;
    assign n2  = p2 ^ n1;
    assign n3  = p3 ^ n2;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_idx  = 4'd0;
        wr_data = '0;
        case (state_q)
            IDLE, DONE: begin
                if (KEY_START) begin
                    wr_en   = 1'b1;
                    wr_data = CIPHER_KEY;
                    cnt_d   = 4'd1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                wr_en   = 1'b1;
                wr_idx  = cnt_q;
                wr_data = {n0, n1, n2, n3};
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            rk_out_q <= '0;
            for (int i = 0; i <= NROUNDS; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            if (wr_en) begin
                rk_q[wr_idx] <= wr_data;
            end
            rk_out_q <= (RK_INDEX > LAST) ? '0 : rk_q[RK_INDEX];
        end
    end

    assign KEY_BUSY  = (state_q == EXPAND);
    assign KEY_READY = (state_q == DONE);
    assign RK_OUT    = rk_out_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - randomized self-checking bench for aes_key_schedule
// Reference keys come from a FIPS-197 word expansion with an S-box derived from GF(2^8).

module tb_aes_key_schedule;
    logic         clk;
    logic         resetn;
    logic         key_start;
    logic [127:0] cipher_key;
    logic         key_busy;
    logic         key_ready;
    logic [3:0]   rk_index;
    logic [127:0] rk_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] exp_rk [11];

    aes_key_schedule #(.NROUNDS(10)) dut (
        .CLK        (clk),
        .RESET_N    (resetn),
        .KEY_START  (key_start),
        .CIPHER_KEY (cipher_key),
        .KEY_BUSY   (key_busy),
        .KEY_READY  (key_ready),
        .RK_INDEX   (rk_index),
        .RK_OUT     (rk_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v};
        d = d << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_ref(tmp[31:24]), sbox_ref(tmp[23:16]),
                       sbox_ref(tmp[15:8]), sbox_ref(tmp[7:0])} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic model_clear();
        for (int r = 0; r < 11; r++) exp_rk[r] = '0;
    endtask

    // Tasks below start and end just after a falling edge.
    task automatic start_key(input logic [127:0] key);
        cipher_key = key;
        key_start  = 1'b1;
        @(negedge clk);
        key_start  = 1'b0;
        cipher_key = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_ready(output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < 30 && !key_ready; i++) begin
            if (key_busy) busy_cycles++;
            @(negedge clk);
        end
        check_eq("ready_reached", 128'(key_ready), 128'd1);
    endtask

    task automatic read_rk(input int idx, output logic [127:0] val);
        rk_index = 4'(idx);
        @(negedge clk);
        val = rk_out;
    endtask

    task automatic sweep(input string tag);
        rk_index = 4'd0;
        @(negedge clk);
        for (int i = 1; i <= 16; i++) begin
            check_eq($sformatf("%s_rk%0d", tag, i - 1), rk_out,
                     (i - 1 <= 10) ? exp_rk[i-1] : 128'h0);
            if (i < 16) begin
                rk_index = 4'(i);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [127:0] v;
        logic [127:0] key_a, key_b;
        int cyc;

        resetn     = 1'b0;
        key_start  = 1'b0;
        cipher_key = '0;
        rk_index   = 4'd0;

        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("idle_busy", 128'(key_busy), 128'd0);
            check_eq("idle_ready", 128'(key_ready), 128'd0);
        end
        model_clear();
        sweep("reset");

        key_a = 128'h000102030405060708090a0b0c0d0e0f;
        model_expand(key_a);
        check_eq("model_c1_rk1", exp_rk[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        start_key(key_a);
        check_eq("c1_busy_after_start", 128'(key_busy), 128'd1);
        wait_ready(cyc);
        check_eq("c1_busy_cycles", 128'(cyc), 128'd10);
        check_eq("c1_busy_done", 128'(key_busy), 128'd0);
        read_rk(1, v);
        check_eq("c1_rk1", v, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        read_rk(10, v);
        check_eq("c1_rk10", v, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        read_rk(0, v);
        check_eq("c1_rk0", v, key_a);
        sweep("c1");

        key_b = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        model_expand(key_b);
        start_key(key_b);
        check_eq("restart_ready_drop", 128'(key_ready), 128'd0);
        wait_ready(cyc);
        check_eq("restart_busy_cycles", 128'(cyc), 128'd10);
        read_rk(10, v);
        check_eq("restart_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        sweep("restart");

        for (int it = 0; it < 4; it++) begin
            key_a = {$urandom, $urandom, $urandom, $urandom};
            key_b = {$urandom, $urandom, $urandom, $urandom};
            model_expand(key_a);
            start_key(key_a);
            repeat (3) @(negedge clk);
            start_key(key_b);
            wait_ready(cyc);
            check_eq($sformatf("ignore%0d_busy_cycles", it), 128'(cyc), 128'd6);
            sweep($sformatf("ignore%0d", it));
        end

        key_a = {$urandom, $urandom, $urandom, $urandom};
        start_key(key_a);
        repeat (4) @(negedge clk);
        resetn    = 1'b0;
        key_start = 1'b1;
        @(negedge clk);
        resetn    = 1'b1;
        key_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check_eq("midreset_busy", 128'(key_busy), 128'd0);
            check_eq("midreset_ready", 128'(key_ready), 128'd0);
            @(negedge clk);
        end
        model_clear();
        sweep("midreset");

        key_a = {$urandom, $urandom, $urandom, $urandom};
        model_expand(key_a);
        start_key(key_a);
        wait_ready(cyc);
        check_eq("after_reset_busy_cycles", 128'(cyc), 128'd10);
        sweep("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
